// File: rtl/johnson_seq_gen_pkg.sv
// jsg_pkg: mode/dir encodings and start-state helper shared by the
// johnson_seq_gen block (optional feature macro: JSG_ILLEGAL_RECOVER_EN).
package jsg_pkg;

    typedef enum logic {
        MODE_JOHNSON = 1'b0,
        MODE_RING    = 1'b1
    } jsg_mode_e;

    typedef enum logic {
        DIR_MSB = 1'b0,   // shift toward MSB
        DIR_LSB = 1'b1    // shift toward LSB
    } jsg_dir_e;

    localparam int JSG_MAX_W = 64;

    // Start state: all zeros for Johnson, one-hot LSB for ring.
    // Callers size-cast the result down to their own WIDTH.
    function automatic logic [JSG_MAX_W-1:0] start_state(input int width, input jsg_mode_e mode);
        logic [JSG_MAX_W-1:0] res;
        res = '0;
        if (mode == MODE_RING && width > 0) res[0] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/johnson_seq_gen_if.sv
// Control/status bundle for johnson_seq_gen. The testbench or parent block
// drives through master; the generator sits on slave.
interface johnson_seq_gen_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
);
    logic             en;
    logic             mode;
    logic             dir;
    logic [DIV_W-1:0] div;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             wrap;
    logic             err;

    modport master (
        output en, mode, dir, div, ld, ld_val,
        input  q, tick, wrap, err
    );

    modport slave (
        input  en, mode, dir, div, ld, ld_val,
        output q, tick, wrap, err
    );
endinterface

// File: rtl/johnson_seq_gen_prescaler.sv
// jsg_prescaler: counts 0..div while enabled and flags the step cycle.
// Using cnt >= div lets a div shrunk below the running count step on the
// very next enabled cycle instead of wrapping through the full counter.
module jsg_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             clear,
    output logic             step
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign step = en && (cnt_q >= div);

    // Next count: clear wins, otherwise advance or restart on a step.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)   cnt_d = '0;
        else if (en) cnt_d = step ? '0 : cnt_q + DIV_W'(1);
    end

    // Count register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/johnson_seq_gen.sv
// johnson_seq_gen: prescaled Johnson / ring sequence generator with load,
// mode-change reload and registered tick/wrap pulses.
// Optional macro JSG_ILLEGAL_RECOVER_EN adds an illegal-state check on each
// step (reload start state and pulse err); without it err is tied low.
module johnson_seq_gen
    import jsg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic              clk,
    input  logic              clr,
    johnson_seq_gen_if.slave  bus
);
    logic [WIDTH-1:0] q_q, q_d, nxt;
    logic [WIDTH-1:0] start_in, start_cur;
    jsg_mode_e        mode_q, mode_in;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             step, mode_chg, pre_clear;

    assign mode_in   = jsg_mode_e'(bus.mode);
    assign start_in  = WIDTH'(start_state(WIDTH, mode_in));
    assign start_cur = WIDTH'(start_state(WIDTH, mode_q));
    assign mode_chg  = (mode_in != mode_q);
    assign pre_clear = bus.ld | mode_chg;

    jsg_prescaler #(.DIV_W(DIV_W)) u_pre (
        .clk   (clk),
        .clr   (clr),
        .en    (bus.en),
        .div   (bus.div),
        .clear (pre_clear),
        .step  (step)
    );

`ifdef JSG_ILLEGAL_RECOVER_EN
    logic err_q, err_d;

    // Johnson codes have at most two bit transitions around the ring;
    // ring codes are exactly one-hot.
    function automatic logic is_legal(input logic [WIDTH-1:0] v, input jsg_mode_e m);
        int unsigned ones, edges;
        ones  = 0;
        edges = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones  += 32'(v[i]);
            edges += 32'(v[i] != v[(i + 1) % WIDTH]);
        end
        return (m == MODE_RING) ? (ones == 1) : (edges <= 2);
    endfunction
`endif

    // Shift candidate for the current mode and direction.
    always_comb begin
        nxt = q_q;
        if (mode_q == MODE_JOHNSON) begin
            if (bus.dir == DIR_LSB) nxt = {~q_q[0], q_q[WIDTH-1:1]};
            else                    nxt = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        end else begin
            if (bus.dir == DIR_LSB) nxt = {q_q[0], q_q[WIDTH-1:1]};
            else                    nxt = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        end
    end

    // Next state: load beats mode reload beats a prescaler step.
    always_comb begin
        q_d    = q_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
`ifdef JSG_ILLEGAL_RECOVER_EN
        err_d  = 1'b0;
`endif
        if (bus.ld) begin
            q_d = bus.ld_val;
        end else if (mode_chg) begin
            q_d = start_in;
        end else if (step) begin
            tick_d = 1'b1;
`ifdef JSG_ILLEGAL_RECOVER_EN
            if (!is_legal(q_q, mode_q)) begin
                q_d   = start_cur;
                err_d = 1'b1;
            end else begin
                q_d    = nxt;
                wrap_d = (nxt == start_cur);
            end
`else
            q_d    = nxt;
            wrap_d = (nxt == start_cur);
`endif
        end
    end

    // State and pulse registers; reset lands in the start state of the
    // mode input so release produces no pulse and no mode-change reload.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q    <= start_in;
            mode_q <= mode_in;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            mode_q <= mode_in;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef JSG_ILLEGAL_RECOVER_EN
    // Recovery pulse register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.q    = q_q;
    assign bus.tick = tick_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_johnson_seq_gen.sv
// Bench for johnson_seq_gen (WIDTH=4, DIV_W=4): directed scenarios with
// literal expectations, then randomized stimulus against a sequence-index
// model. Honors JSG_ILLEGAL_RECOVER_EN the same way as the design.
module tb_johnson_seq_gen;
    localparam int W  = 4;
    localparam int DW = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    johnson_seq_gen_if #(.WIDTH(W), .DIV_W(DW)) bus();
    johnson_seq_gen #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int m_q, m_cnt, m_mode;
    int m_tick, m_wrap, m_err;

    // k-th value of the Johnson cycle: k ones filling from LSB, then
    // zeros filling from LSB.
    function automatic int jtab(input int k);
        if (k <= W) return (1 << k) - 1;
        return MASK ^ ((1 << (k - W)) - 1);
    endfunction

    function automatic int period(input int mode);
        return mode ? W : 2 * W;
    endfunction

    function automatic int seq_val(input int mode, input int k);
        return mode ? (1 << k) : jtab(k);
    endfunction

    function automatic int find_idx(input int mode, input int v);
        for (int k = 0; k < period(mode); k++)
            if (seq_val(mode, k) == v) return k;
        return -1;
    endfunction

    function automatic int start_of(input int mode);
        return seq_val(mode, 0);
    endfunction

    // Bit-level shift, only needed for values outside the legal cycle.
    function automatic int raw_shift(input int mode, input int dir, input int v);
        int b0, bt;
        b0 = v & 1;
        bt = (v >> (W - 1)) & 1;
        if (mode == 0) begin
            if (dir == 0) return ((v << 1) & MASK) | (bt ^ 1);
            return (v >> 1) | ((b0 ^ 1) << (W - 1));
        end
        if (dir == 0) return ((v << 1) & MASK) | bt;
        return (v >> 1) | (b0 << (W - 1));
    endfunction

    task automatic model_step();
        int idx, p;
        idx = find_idx(m_mode, m_q);
        p   = period(m_mode);
        m_tick = 1;
        if (idx >= 0) begin
            m_q    = seq_val(m_mode, (idx + (bus.dir ? p - 1 : 1)) % p);
            m_wrap = (m_q == start_of(m_mode));
        end else begin
`ifdef JSG_ILLEGAL_RECOVER_EN
            m_q   = start_of(m_mode);
            m_err = 1;
`else
            m_q    = raw_shift(m_mode, int'(bus.dir), m_q);
            m_wrap = (m_q == start_of(m_mode));
`endif
        end
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        m_tick = 0; m_wrap = 0; m_err = 0;
        if (bus.ld) begin
            m_q = int'(bus.ld_val); m_cnt = 0; m_mode = int'(bus.mode);
        end else if (int'(bus.mode) != m_mode) begin
            m_mode = int'(bus.mode); m_q = start_of(m_mode); m_cnt = 0;
        end else if (bus.en) begin
            if (m_cnt >= int'(bus.div)) begin
                m_cnt = 0;
                model_step();
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("q",    32'(bus.q),    m_q);
        check("tick", 32'(bus.tick), m_tick);
        check("wrap", 32'(bus.wrap), m_wrap);
        check("err",  32'(bus.err),  m_err);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    // Asynchronous clear pulse placed between clock edges.
    task automatic do_reset(input int mode);
        bus.mode = mode[0];
        clr = 1'b1;
        #1;
        m_q = start_of(mode); m_cnt = 0; m_mode = mode;
        m_tick = 0; m_wrap = 0; m_err = 0;
        compare_all();
        check("rst_q", 32'(bus.q), mode ? 1 : 0);
        #1;
        clr = 1'b0;
    endtask

    int jexp[8] = '{1, 3, 7, 15, 14, 12, 8, 0};
    int rexp[4] = '{8, 4, 2, 1};

    initial begin
        bus.en = 1'b1; bus.mode = 1'b0; bus.dir = 1'b0; bus.div = '0;
        bus.ld = 1'b0; bus.ld_val = '0;
        clr = 1'b0;
        do_reset(0);

        // Johnson, toward MSB, step every cycle: full period, wrap at end
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("j_seq",  32'(bus.q),    jexp[i]);
            check("j_wrap", 32'(bus.wrap), (i == 7) ? 1 : 0);
        end

        // Run to 0111, then flip to ring: reload one-hot LSB, no pulses
        repeat (3) cyc();
        check("j_0111", 32'(bus.q), 7);
        bus.mode = 1'b1;
        cyc();
        check("mchg_q",    32'(bus.q),    1);
        check("mchg_tick", 32'(bus.tick), 0);
        check("mchg_wrap", 32'(bus.wrap), 0);
        // one enabled cycle (count 1 of 0..2), freeze, then resume
        bus.div = 4'd2;
        cyc();
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("frz_q", 32'(bus.q), 1);
        end
        bus.en = 1'b1;
        cyc();
        check("frz_resume_tick", 32'(bus.tick), 0);
        cyc();
        check("frz_step_q",    32'(bus.q),    2);
        check("frz_step_tick", 32'(bus.tick), 1);

        // Ring toward LSB, step every 3 cycles
        bus.dir = 1'b1;
        bus.div = 4'd2;
        do_reset(1);
        for (int e = 1; e <= 12; e++) begin
            cyc();
            check("r_tick", 32'(bus.tick), (e % 3 == 0) ? 1 : 0);
            if (e % 3 == 0) begin
                check("r_seq",  32'(bus.q),    rexp[e / 3 - 1]);
                check("r_wrap", 32'(bus.wrap), (e == 12) ? 1 : 0);
            end
        end

        // Load an illegal Johnson value, then step it
        bus.dir = 1'b0;
        bus.div = 4'd0;
        do_reset(0);
        bus.ld = 1'b1; bus.ld_val = 4'b0101;
        cyc();
        check("ld_q",    32'(bus.q),    5);
        check("ld_tick", 32'(bus.tick), 0);
        bus.ld = 1'b0;
        cyc();
        check("ill_tick", 32'(bus.tick), 1);
        check("ill_wrap", 32'(bus.wrap), 0);
`ifdef JSG_ILLEGAL_RECOVER_EN
        check("ill_q",   32'(bus.q),   0);
        check("ill_err", 32'(bus.err), 1);
`else
        // 0101 shifted toward MSB with the inverted MSB fed into bit 0
        check("ill_q",   32'(bus.q),   4'b1011);
        check("ill_err", 32'(bus.err), 0);
`endif

        // Clear mid-count at q=1100 with mode input set to ring
        bus.div = 4'd1;
        bus.ld = 1'b1; bus.ld_val = 4'b1100;
        cyc();
        bus.ld = 1'b0;
        cyc();
        check("pre_clr_q",    32'(bus.q),    12);
        check("pre_clr_tick", 32'(bus.tick), 0);
        do_reset(1);
        cyc();
        check("rel_q",    32'(bus.q),    1);
        check("rel_tick", 32'(bus.tick), 0);
        check("rel_wrap", 32'(bus.wrap), 0);
        check("rel_err",  32'(bus.err),  0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc();
            bus.en     = ($urandom % 8) != 0;
            bus.ld     = ($urandom % 20) == 0;
            bus.ld_val = 4'($urandom % 16);
            if ($urandom % 25 == 0) bus.mode = ~bus.mode;
            if ($urandom % 6 == 0)  bus.dir  = 1'($urandom % 2);
            if ($urandom % 10 == 0) bus.div  = 4'($urandom % 5);
            if ($urandom % 60 == 0) do_reset(int'($urandom % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
